// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : MEM/WB pipeline register and write-back select for the 8-bit
//             pipelined core. Captures the MEM-stage result (ALU value and
//             data-memory read word) with destination/control, drives the
//             register-file write port one cycle later and flags EX-stage
//             forwarding hits on the write-back value.
//  Ports    : clk, rst (sync, active-high)
//             i_stall, i_flush            - hold / bubble control
//             i_valid_in, i_reg_write_in,
//             i_mem_to_reg_in, i_rd_in,
//             i_aluout_in, i_memtoreg_in  - MEM-stage result
//             i_rs1_ex, i_rs2_ex          - EX-stage source registers
//             o_wb_en, o_wb_addr, o_wb_data
//             o_fwd_a_hit, o_fwd_b_hit
//             o_retire_count              - only with RETIRE_COUNT_EN
//  Options  : `define RETIRE_COUNT_EN adds the retired-instruction counter.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
  parameter int DATA_W       = 8,
  parameter int REG_ADDR_W   = 3,
  parameter int R0_HARDWIRED = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_valid_in,
  input  logic                  i_reg_write_in,
  input  logic                  i_mem_to_reg_in,
  input  logic [REG_ADDR_W-1:0] i_rd_in,
  input  logic [DATA_W-1:0]     i_aluout_in,
  input  logic [DATA_W-1:0]     i_memtoreg_in,
  input  logic [REG_ADDR_W-1:0] i_rs1_ex,
  input  logic [REG_ADDR_W-1:0] i_rs2_ex,
  output logic                  o_wb_en,
  output logic [REG_ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0]     o_wb_data,
  output logic                  o_fwd_a_hit,
  output logic                  o_fwd_b_hit
`ifdef RETIRE_COUNT_EN
  ,
  output logic [CNT_W-1:0]      o_retire_count
`endif
);

  localparam logic c_R0_HW = (R0_HARDWIRED != 0);

  logic                  r_valid;
  logic                  r_rw;
  logic                  r_m2r;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_alu;
  logic [DATA_W-1:0]     r_mem;

  logic w_r0_dest;
  logic w_wb_en;

  // Stage registers: rst > flush > stall > load.
  // On flush only the valid bit matters; the payload simply holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rw    <= 1'b0;
      r_m2r   <= 1'b0;
      r_rd    <= '0;
      r_alu   <= '0;
      r_mem   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (!i_stall) begin
      r_valid <= i_valid_in;
      r_rw    <= i_reg_write_in;
      r_m2r   <= i_mem_to_reg_in;
      r_rd    <= i_rd_in;
      r_alu   <= i_aluout_in;
      r_mem   <= i_memtoreg_in;
    end
  end

  // Register 0 is a constant zero when hardwired: no write, no forward.
  assign w_r0_dest = c_R0_HW & (r_rd == '0);
  assign w_wb_en   = r_valid & r_rw & ~w_r0_dest;

  assign o_wb_en     = w_wb_en;
  assign o_wb_addr   = r_rd;
  assign o_wb_data   = r_m2r ? r_mem : r_alu;
  assign o_fwd_a_hit = w_wb_en & (i_rs1_ex == r_rd);
  assign o_fwd_b_hit = w_wb_en & (i_rs2_ex == r_rd);

`ifdef RETIRE_COUNT_EN
  logic [CNT_W-1:0] r_retire_count;

  // An instruction retires on the edge that moves it out of WB: valid and
  // not held. A flush on that edge does not cancel the retiring instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_count <= '0;
    end else if (r_valid && !i_stall) begin
      r_retire_count <= r_retire_count + 1'b1;
    end
  end

  assign o_retire_count = r_retire_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Purpose  : Self-checking bench for mem_wb_stage. A reference model of the
//             stage state produces the expected write-back outputs for every
//             driven cycle; they are queued and compared after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

`ifdef RETIRE_COUNT_EN
  localparam int c_CNT_W = 4;
`else
  localparam int c_CNT_W = 16;
`endif

  logic       clk = 1'b0;
  logic       rst, stall, flush, valid_in, rw_in, m2r_in;
  logic [2:0] rd_in, rs1_ex, rs2_ex;
  logic [7:0] alu_in, mem_in;
  logic       wb_en, fwd_a, fwd_b;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [c_CNT_W-1:0] retire_count;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(8), .REG_ADDR_W(3), .R0_HARDWIRED(1), .CNT_W(c_CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_stall         (stall),
    .i_flush         (flush),
    .i_valid_in      (valid_in),
    .i_reg_write_in  (rw_in),
    .i_mem_to_reg_in (m2r_in),
    .i_rd_in         (rd_in),
    .i_aluout_in     (alu_in),
    .i_memtoreg_in   (mem_in),
    .i_rs1_ex        (rs1_ex),
    .i_rs2_ex        (rs2_ex),
    .o_wb_en         (wb_en),
    .o_wb_addr       (wb_addr),
    .o_wb_data       (wb_data),
    .o_fwd_a_hit     (fwd_a),
    .o_fwd_b_hit     (fwd_b)
`ifdef RETIRE_COUNT_EN
    ,
    .o_retire_count  (retire_count)
`endif
  );

`ifndef RETIRE_COUNT_EN
  assign retire_count = '0;
`endif

  typedef struct {
    logic               en;
    logic               ad_known;
    logic [2:0]         addr;
    logic [7:0]         data;
    logic [c_CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model of the stage state.
  logic               m_valid, m_rw, m_m2r, m_known;
  logic [2:0]         m_rd;
  logic [7:0]         m_alu, m_mem;
  logic [c_CNT_W-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  // Drive one cycle, advance the model, queue the expectation, then compare
  // after the edge.
  task automatic cycle(input logic r, input logic s, input logic f,
                       input logic v, input logic w, input logic m,
                       input logic [2:0] rd, input logic [7:0] a, input logic [7:0] mm,
                       input string tag);
    exp_t e, g;
    rst = r; stall = s; flush = f;
    valid_in = v; rw_in = w; m2r_in = m; rd_in = rd; alu_in = a; mem_in = mm;
    if (r) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_mem = 0;
      m_cnt = 0; m_known = 1;
    end else begin
      if (m_valid && !s) m_cnt = m_cnt + 1'b1;
      if (f) begin
        m_valid = 0; m_known = 0;
      end else if (!s) begin
        m_valid = v; m_rw = w; m_m2r = m; m_rd = rd; m_alu = a; m_mem = mm;
        m_known = 1;
      end
    end
    e.en       = m_valid & m_rw & (m_rd != 3'd0);
    e.ad_known = m_known;
    e.addr     = m_rd;
    e.data     = m_m2r ? m_mem : m_alu;
    e.cnt      = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check({tag, ".wb_en"}, {31'd0, wb_en}, {31'd0, g.en});
    if (g.ad_known) begin
      check({tag, ".wb_addr"}, {29'd0, wb_addr}, {29'd0, g.addr});
      check({tag, ".wb_data"}, {24'd0, wb_data}, {24'd0, g.data});
    end
`ifdef RETIRE_COUNT_EN
    check({tag, ".retire"}, 32'(retire_count), 32'(g.cnt));
`endif
  endtask

  initial begin : main
    logic [c_CNT_W-1:0] cnt_ref;
    rst = 1; stall = 0; flush = 0; valid_in = 0; rw_in = 0; m2r_in = 0;
    rd_in = 0; alu_in = 0; mem_in = 0; rs1_ex = 0; rs2_ex = 0;
    m_valid = 0; m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_mem = 0;
    m_cnt = 0; m_known = 0;

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++)
      cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 8'($urandom), 8'($urandom), "reset");
    rs1_ex = 0; rs2_ex = 0; #1;
    check("rst.wb_en", {31'd0, wb_en}, 0);
    check("rst.wb_addr", {29'd0, wb_addr}, 0);
    check("rst.wb_data", {24'd0, wb_data}, 0);
    check("rst.fwd_a", {31'd0, fwd_a}, 0);
    check("rst.fwd_b", {31'd0, fwd_b}, 0);
    check("rst.retire", 32'(retire_count), 0);

    // 2: ALU write-back
    cycle(0, 0, 0, 1, 1, 0, 3'd3, 8'h5A, 8'hC3, "alu");
    check("alu.en", {31'd0, wb_en}, 1);
    check("alu.addr", {29'd0, wb_addr}, 3);
    check("alu.data", {24'd0, wb_data}, 32'h5A);

    // 3: load write-back and forwarding
    cycle(0, 0, 0, 1, 1, 1, 3'd5, 8'h21, 8'hC3, "load");
    rs1_ex = 3'd5; rs2_ex = 3'd5; #1;
    check("load.data", {24'd0, wb_data}, 32'hC3);
    check("load.fwd_a", {31'd0, fwd_a}, 1);
    check("load.fwd_b", {31'd0, fwd_b}, 1);
    rs2_ex = 3'd2; #1;
    check("load.fwd_b_miss", {31'd0, fwd_b}, 0);
    check("load.fwd_a_keep", {31'd0, fwd_a}, 1);

    // 4: register 0 suppression
    cycle(0, 0, 0, 1, 1, 0, 3'd0, 8'hFF, 8'h00, "r0");
    rs1_ex = 3'd0; rs2_ex = 3'd0; #1;
    check("r0.en", {31'd0, wb_en}, 0);
    check("r0.fwd_a", {31'd0, fwd_a}, 0);

    // bubble with reg_write set
    cycle(0, 0, 0, 0, 1, 0, 3'd6, 8'h77, 8'h00, "bubble");
    rs1_ex = 3'd6; #1;
    check("bubble.fwd_a", {31'd0, fwd_a}, 0);

    // 5: stall then flush
    cycle(0, 0, 0, 1, 1, 0, 3'd4, 8'h11, 8'h00, "st_load");
    cnt_ref = retire_count;
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 0, 1, 1, 1, 3'(i + 1), 8'(8'hA0 + i), 8'hEE, "stall");
    check("stall.addr", {29'd0, wb_addr}, 4);
    check("stall.data", {24'd0, wb_data}, 32'h11);
    check("stall.en", {31'd0, wb_en}, 1);
    check("stall.retire_hold", 32'(retire_count), 32'(cnt_ref));
    cycle(0, 1, 1, 1, 1, 0, 3'd7, 8'h99, 8'h00, "flush");
    check("flush.en", {31'd0, wb_en}, 0);

    // reset asserted during stall and flush
    cycle(0, 0, 0, 1, 1, 0, 3'd2, 8'h42, 8'h00, "pre_rst");
    cycle(1, 1, 1, 1, 1, 0, 3'd2, 8'h43, 8'h00, "rst_mid");
    check("rst_mid.addr", {29'd0, wb_addr}, 0);

    // 6: retire counter wrap; 18 consecutive valid edges after reset
    for (int i = 0; i < 18; i++)
      cycle(0, 0, 0, 1, 1, 0, 3'(i % 7 + 1), 8'(i), 8'h00, "wrap");
`ifdef RETIRE_COUNT_EN
    check("wrap.final", 32'(retire_count), 1);
`endif

    // random mixed traffic
    for (int i = 0; i < 40; i++)
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 8'($urandom), 8'($urandom), "rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
